// File: rtl/timer_pkg.sv
//------------------------------------------------------------------------------
// timer_pkg
//   Shared state encoding and default constants for timer_cmd_tx.
//   ST_ABORT exists only when TIMER_CMD_TX_WATCHDOG_EN is defined.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

`ifdef TIMER_CMD_TX_WATCHDOG_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DLY   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4,
        ST_ABORT = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DLY   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4
    } state_t;
`endif

    localparam logic [3:0] c_pattern_default     = 4'b1101;
    localparam int         c_unit_cycles_default = 1000;
    localparam int         c_wd_cnt_w            = 15;

endpackage

`default_nettype wire

// File: rtl/timer_bit_serializer.sv
//------------------------------------------------------------------------------
// timer_bit_serializer
//   4-bit MSB-first serializer with load, shift and last-bit flag.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_bit_serializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       shift,
    output logic       bit_next,
    output logic       last
);

    logic [3:0] sreg_q, sreg_d;
    logic [1:0] idx_q, idx_d;

    always_comb begin
        sreg_d = sreg_q;
        idx_d  = idx_q;
        if (load) begin
            sreg_d = load_val;
            idx_d  = 2'd3;
        end else if (shift) begin
            idx_d  = idx_q - 2'd1;
        end
    end

    // Look-ahead bit lets the parent register it so it lands on data in step with idx.
    assign bit_next = sreg_d[idx_d];
    assign last     = (idx_q == 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= 4'd0;
            idx_q  <= 2'd3;
        end else begin
            sreg_q <= sreg_d;
            idx_q  <= idx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_cmd_tx.sv
//------------------------------------------------------------------------------
// timer_cmd_tx
//   Sends start pattern + 4-bit delay to a timer, then runs the done/ack
//   handshake. TIMER_CMD_TX_WATCHDOG_EN adds a WAIT watchdog and ABORT state.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_cmd_tx
    import timer_pkg::*;
#(
    parameter logic [3:0] PATTERN     = c_pattern_default,
    parameter int         UNIT_CYCLES = c_unit_cycles_default,
    parameter int         WD_SLACK    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] delay_in,
    input  logic       done,
    output logic       data,
    output logic       ack,
    output logic       busy,
    output logic       cmd_done,
    output logic       timeout
);

    state_t     state_q, state_d;
    logic [3:0] dly_q, dly_d;
    logic       data_q, data_d;
    logic       ack_q, ack_d;
    logic       cmd_done_q, cmd_done_d;

    logic       w_load;
    logic [3:0] w_load_val;
    logic       w_shift;
    logic       w_bit_next;
    logic       w_last;

`ifdef TIMER_CMD_TX_WATCHDOG_EN
    localparam logic [c_wd_cnt_w-1:0] c_unit  = c_wd_cnt_w'(UNIT_CYCLES);
    localparam logic [c_wd_cnt_w-1:0] c_slack = c_wd_cnt_w'(WD_SLACK);

    logic [c_wd_cnt_w-1:0] wd_cnt_q, wd_cnt_d;
    logic [c_wd_cnt_w-1:0] w_wd_limit;
    logic                  timeout_q, timeout_d;

    // 16 * 1000 + 16 fits in 15 bits, so no overflow at the maximum delay.
    assign w_wd_limit = ({{(c_wd_cnt_w-4){1'b0}}, dly_q} + c_wd_cnt_w'(1)) * c_unit + c_slack;
`else
    logic w_unused_wd_slack;
    assign w_unused_wd_slack = ^(32'(WD_SLACK));
`endif

    timer_bit_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .shift    (w_shift),
        .bit_next (w_bit_next),
        .last     (w_last)
    );

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        w_load     = 1'b0;
        w_load_val = PATTERN;
        w_shift    = 1'b0;
        cmd_done_d = 1'b0;
`ifdef TIMER_CMD_TX_WATCHDOG_EN
        timeout_d  = 1'b0;
        wd_cnt_d   = (state_q == ST_WAIT) ? wd_cnt_q + c_wd_cnt_w'(1) : '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dly_d      = delay_in;
                    w_load     = 1'b1;
                    w_load_val = PATTERN;
                    state_d    = ST_PRE;
                end
            end
            ST_PRE: begin
                if (w_last) begin
                    w_load     = 1'b1;
                    w_load_val = dly_q;
                    state_d    = ST_DLY;
                end else begin
                    w_shift    = 1'b1;
                end
            end
            ST_DLY: begin
                if (w_last) begin
                    state_d = ST_WAIT;
                end else begin
                    w_shift = 1'b1;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    state_d = ST_ACK;
`ifdef TIMER_CMD_TX_WATCHDOG_EN
                end else if (wd_cnt_q == w_wd_limit) begin
                    state_d   = ST_ABORT;
                    timeout_d = 1'b1;
`endif
                end
            end
            ST_ACK: begin
                if (!done) begin
                    state_d    = ST_IDLE;
                    cmd_done_d = 1'b1;
                end
            end
`ifdef TIMER_CMD_TX_WATCHDOG_EN
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        data_d = ((state_d == ST_PRE) || (state_d == ST_DLY)) ? w_bit_next : 1'b0;
`ifdef TIMER_CMD_TX_WATCHDOG_EN
        ack_d  = (state_d == ST_ACK) || (state_d == ST_ABORT);
`else
        ack_d  = (state_d == ST_ACK);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dly_q      <= 4'd0;
            data_q     <= 1'b0;
            ack_q      <= 1'b0;
            cmd_done_q <= 1'b0;
`ifdef TIMER_CMD_TX_WATCHDOG_EN
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            cmd_done_q <= cmd_done_d;
`ifdef TIMER_CMD_TX_WATCHDOG_EN
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign data     = data_q;
    assign ack      = ack_q;
    assign busy     = (state_q != ST_IDLE);
    assign cmd_done = cmd_done_q;
`ifdef TIMER_CMD_TX_WATCHDOG_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_cmd_tx.sv
//------------------------------------------------------------------------------
// tb_timer_cmd_tx
//   Scoreboard bench for timer_cmd_tx: stimulus queues expected frames, ack
//   widths and end events; a monitor pops and compares them.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_cmd_tx;

    localparam int c_unit   = 1000;
    localparam int EV_DONE  = 1;
    localparam int EV_TMO   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] delay_in;
    logic       done;
    logic       data;
    logic       ack;
    logic       busy;
    logic       cmd_done;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_frame[$];
    int         exp_ackw[$];
    int         exp_end[$];

    always #5 clk = ~clk;

    timer_cmd_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .delay_in (delay_in),
        .done     (done),
        .data     (data),
        .ack      (ack),
        .busy     (busy),
        .cmd_done (cmd_done),
        .timeout  (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // Monitor: reacts to what the DUT presents and pops the scoreboard.
    initial begin
        logic       prev_busy;
        logic       prev_ack;
        logic [7:0] frame;
        int         bitcnt;
        int         ackw;
        bit         chk_after;
        prev_busy = 1'b0;
        prev_ack  = 1'b0;
        frame     = 8'd0;
        bitcnt    = -1;
        ackw      = 0;
        chk_after = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_after) begin
                check("data_after_frame", data, 0);
                chk_after = 1'b0;
            end
            if (busy && !prev_busy) begin
                bitcnt = 0;
                frame  = 8'd0;
            end
            if (!busy) bitcnt = -1;
            if (bitcnt >= 0 && bitcnt < 8) begin
                frame = {frame[6:0], data};
                bitcnt++;
                if (bitcnt == 8) begin
                    if (exp_frame.size() == 0) unexpected("frame");
                    else check("frame", frame, exp_frame.pop_front());
                    chk_after = 1'b1;
                    bitcnt    = -1;
                end
            end
            if (ack) begin
                ackw++;
            end else if (prev_ack) begin
                if (exp_ackw.size() == 0) unexpected("ack_width");
                else check("ack_width", ackw, exp_ackw.pop_front());
                ackw = 0;
            end
            if (cmd_done) begin
                if (exp_end.size() == 0) unexpected("cmd_done");
                else check("end_cmd_done", EV_DONE, exp_end.pop_front());
                check("busy_at_cmd_done", busy, 0);
                check("ack_at_cmd_done", ack, 0);
            end
            if (timeout) begin
                if (exp_end.size() == 0) unexpected("timeout");
                else check("end_timeout", EV_TMO, exp_end.pop_front());
            end
            prev_busy = busy;
            prev_ack  = ack;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge of the first cycle after start is sampled.
    task automatic issue(input logic [3:0] d);
        start    = 1'b1;
        delay_in = d;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_ack_drop_done(input int limit);
        int n;
        n = 0;
        while (!ack && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", ack, 1);
        done = 1'b0;
    endtask

    // Timer receiver: decodes the frame, counts (d+1)*unit cycles, then handshakes.
    task automatic rx_model(output logic [3:0] d);
        logic [7:0] bits;
        bits = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bits = {bits[6:0], data};
            if (i < 7) @(negedge clk);
        end
        check("rx_header", bits[7:4], 4'hD);
        d = bits[3:0];
        for (int n = 0; n < (int'(d) + 1) * c_unit; n++) @(negedge clk);
        done = 1'b1;
        wait_ack_drop_done(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [3:0] rx_d;
        int         cyc;
        bit         seen_to;

        // Reset held with start and done high: reset must win.
        reset    = 1'b1;
        start    = 1'b1;
        done     = 1'b1;
        delay_in = 4'h7;
        idle(3);
        check("rst_data", data, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        start = 1'b0;
        done  = 1'b0;
        idle(2);

        // Delay 5: stream 1101_0101, done 5000 cycles after the last bit.
        exp_frame.push_back(8'hD5);
        exp_ackw.push_back(1);
        exp_end.push_back(EV_DONE);
        issue(4'h5);
        check("busy_cycle1", busy, 1);
        check("data_cycle1", data, 1);
        idle(7);
        idle(5000);
        check("busy_in_wait", busy, 1);
        done = 1'b1;
        wait_ack_drop_done(20);
        idle(3);
        check("busy_after_t1", busy, 0);

        // Start re-asserted during DLY with 0xF: ignored, not queued.
        exp_frame.push_back(8'hD3);
        exp_ackw.push_back(1);
        exp_end.push_back(EV_DONE);
        issue(4'h3);
        idle(5);
        start    = 1'b1;
        delay_in = 4'hF;
        idle(2);
        start    = 1'b0;
        idle(1);
        check("busy_wait_t2", busy, 1);
        idle(10);
        done = 1'b1;
        wait_ack_drop_done(20);
        idle(6);
        check("no_queued_start", busy, 0);

        // Reset in the 3rd DLY cycle, with start/done also high.
        issue(4'h9);
        idle(6);
        reset = 1'b1;
        start = 1'b1;
        done  = 1'b1;
        @(negedge clk);
        check("midrst_data", data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_done", cmd_done, 0);
        reset = 1'b0;
        start = 1'b0;
        done  = 1'b0;
        idle(2);

        // Start and done together in IDLE; done held is accepted on first WAIT cycle.
        exp_frame.push_back(8'hD6);
        exp_ackw.push_back(1);
        exp_end.push_back(EV_DONE);
        done = 1'b1;
        issue(4'h6);
        check("start_wins_busy", busy, 1);
        idle(9);
        check("ack_first_wait", ack, 1);
        done = 1'b0;
        idle(1);
        check("cmd_done_after_ack", cmd_done, 1);
        idle(2);

`ifdef TIMER_CMD_TX_WATCHDOG_EN
        // Delay 0, no done: limit 1016 -> ABORT 1026 cycles after start.
        exp_frame.push_back(8'hD0);
        exp_ackw.push_back(1);
        exp_end.push_back(EV_TMO);
        issue(4'h0);
        cyc = 1;
        while (!timeout && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycle", cyc, 1026);
        check("ack_in_abort", ack, 1);
        @(negedge clk);
        check("idle_after_abort", busy, 0);
        check("timeout_pulse_1", timeout, 0);
        seen_to = 1'b0;
        idle(2);
`else
        // Without the watchdog WAIT persists; reset mid-WAIT gives no cmd_done.
        exp_frame.push_back(8'hD0);
        issue(4'h0);
        seen_to = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (timeout) seen_to = 1'b1;
        end
        check("no_timeout", seen_to, 0);
        check("wait_persists", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_wait_busy", busy, 0);
        idle(2);
`endif
        cyc = 0;

        // Back-to-back with the receiver model, delay 2.
        exp_frame.push_back(8'hD2);
        exp_ackw.push_back(1);
        exp_end.push_back(EV_DONE);
        issue(4'h2);
        rx_model(rx_d);
        check("rx_delay", rx_d, 4'h2);
        idle(3);
        check("both_idle_busy", busy, 0);
        check("both_idle_ack", ack, 0);

        idle(5);
        check("sb_frames_left", exp_frame.size(), 0);
        check("sb_ackw_left", exp_ackw.size(), 0);
        check("sb_end_left", exp_end.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_cmd_tx.md
TIMER_CMD_TX -- requirements
Module: timer_cmd_tx

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b1101: start pattern, sent MSB first.
REQ-002 SHALL have parameter UNIT_CYCLES, default 1000: timer cycles per delay unit.
REQ-003 SHALL have parameter WD_SLACK, default 16: extra cycles allowed beyond the nominal timer duration; used only when the watchdog is compiled in.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: command request; sampled only in IDLE.
REQ-007 SHALL have port delay_in, input, 4: delay value; captured on an accepted start.
REQ-008 SHALL have port done, input, 1: timer-finished indication from the timer receiver.
REQ-009 SHALL have port data, output, 1: serial command line to the timer; registered.
REQ-010 SHALL have port ack, output, 1: acknowledge to the timer; registered.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port cmd_done, output, 1: one-cycle pulse when the handshake completes.
REQ-013 SHALL have port timeout, output, 1: one-cycle pulse when the watchdog aborts; constant 0 when the watchdog is not compiled in.

Function
REQ-014 SHALL implement the states IDLE, PRE, DLY, WAIT, ACK and, with the watchdog only, ABORT.
REQ-015 In IDLE with start=1, SHALL capture delay_in into dly_q, clear bit index idx to 3, and enter PRE.
REQ-016 In PRE, SHALL drive data=PATTERN[idx] and decrement idx; at idx=0, SHALL enter DLY with idx=3.
REQ-017 In DLY, SHALL drive data=dly_q[idx] and decrement idx; at idx=0, SHALL enter WAIT.
REQ-018 Timing: the first pattern bit SHALL appear on data exactly 1 cycle after start is sampled; the 8 bits SHALL occupy 8 consecutive cycles.
REQ-019 In IDLE, WAIT, ACK and ABORT, data SHALL be 0.
REQ-020 In WAIT, when done is sampled 1, SHALL enter ACK.
REQ-021 In ACK, ack SHALL be 1.
REQ-022 In ACK, when done is sampled 0, SHALL deassert ack, pulse cmd_done for 1 cycle, and return to IDLE.
REQ-023 start SHALL be ignored while busy=1 and SHALL NOT be queued.
REQ-024 done SHALL be ignored outside WAIT and ACK.
REQ-025 A done that is already 1 on entry to WAIT SHALL be accepted on the first WAIT cycle.
REQ-026 When start and done are both high in IDLE, start SHALL win and done SHALL be ignored.

Reset
REQ-027 While reset=1, SHALL force state IDLE, data=0, ack=0, busy=0, cmd_done=0, timeout=0, idx=3, dly_q=0, and wd_cnt=0.
REQ-028 Reset SHALL override start and done in the same cycle.
REQ-029 Reset mid-PRE, mid-DLY, in WAIT or in ACK SHALL abort with no cmd_done pulse.

Configuration
REQ-030 SHALL support the macro TIMER_CMD_TX_WATCHDOG_EN, which compiles the watchdog in.
REQ-031 With TIMER_CMD_TX_WATCHDOG_EN defined: a 15-bit wd_cnt SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-032 With TIMER_CMD_TX_WATCHDOG_EN defined: when wd_cnt = (dly_q+1)*UNIT_CYCLES + WD_SLACK with no done, SHALL enter ABORT.
REQ-033 With TIMER_CMD_TX_WATCHDOG_EN defined: ABORT SHALL pulse timeout for 1 cycle, hold ack=1 for exactly 1 cycle to release the receiver, and then enter IDLE.
REQ-034 With TIMER_CMD_TX_WATCHDOG_EN defined: the limit SHALL be computed at 15-bit width without overflow (max 16016).
REQ-035 Without TIMER_CMD_TX_WATCHDOG_EN: there SHALL be no wd_cnt and no ABORT state; timeout SHALL be tied 0; WAIT SHALL persist indefinitely.

Structure
REQ-036 Package timer_pkg SHALL hold the state enum, the default PATTERN, the UNIT_CYCLES default, and the wd_cnt width constant.
REQ-037 The sub-module timer_bit_serializer SHALL handle the 4-bit MSB-first load/shift/last-bit flag and SHALL be instantiated once, reloaded for the pattern and then for the delay.

Verification
REQ-038 Bench SHALL cover: start=1 with delay_in=4'h5 in IDLE -> data = 1,1,0,1,0,1,0,1 on cycles 1-8 after start, then 0; busy high from cycle 1.
REQ-039 Bench SHALL cover: done raised 5000 cycles after the last bit and dropped 1 cycle after ack rises -> ack high for exactly 1 cycle, cmd_done pulse on the following cycle, busy=0.
REQ-040 Bench SHALL cover: start re-asserted during DLY with delay_in=4'hF -> serial stream unchanged and the original delay bits sent.
REQ-041 Bench SHALL cover: reset asserted in the 3rd DLY cycle -> next cycle data=0, busy=0, no cmd_done; a new start sends the full pattern again.
REQ-042 Bench SHALL cover, with WATCHDOG_EN and delay_in=4'h0 and done never asserted: timeout pulses when wd_cnt reaches 1016, ack is high for 1 cycle, then the block is in IDLE.
REQ-043 Bench SHALL cover, back-to-back with a timer receiver model: delay_in=4'h2 -> receiver done after 3000 counting cycles, and both blocks are idle after the ack handshake.
